// File: rtl/bus_select_encoder_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg: shared definitions for the bus select encoder.
// Holds the source-index map of the datapath bus, the idle select code, the
// encoder FSM state type and the one-hot classification type.
// No ports (package).
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int NUM_SRC  = 24;
  localparam int SEL_W    = 5;
  localparam int CNT_W    = 8;
  // Unmapped mux input: the bus mux drives 32'd0 for this code.
  localparam int IDLE_SEL = 24;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    FAULT
  } bus_enc_state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_ONE,
    CLS_MULTI
  } onehot_cls_t;

endpackage

// File: rtl/bus_select_encoder_if.sv
// -----------------------------------------------------------------------------
// bus_select_encoder_if: control-side bundle between the sequencer and the
// bus select encoder.
//   out_en    : one-hot source strobes (bit i = source i)
//   hold      : freeze the current select
//   fault_ack : one-cycle pulse clearing the FAULT state
//   select    : registered bus mux select
//   bus_valid : select names a real source
//   fault     : encoder is in FAULT
//   fault_cnt : saturating count of multi-driver events
// Modports: master = control sequencer, slave = encoder.
// -----------------------------------------------------------------------------
interface bus_select_encoder_if
  import bus_pkg::*;
#(
  parameter int EN_W  = NUM_SRC,
  parameter int SEL_W = bus_pkg::SEL_W,
  parameter int CNT_W = bus_pkg::CNT_W
);

  logic [EN_W-1:0]  out_en;
  logic             hold;
  logic             fault_ack;
  logic [SEL_W-1:0] select;
  logic             bus_valid;
  logic             fault;
  logic [CNT_W-1:0] fault_cnt;

  modport master (
    output out_en, hold, fault_ack,
    input  select, bus_valid, fault, fault_cnt
  );

  modport slave (
    input  out_en, hold, fault_ack,
    output select, bus_valid, fault, fault_cnt
  );

endinterface

// File: rtl/bus_select_encoder_classify.sv
// -----------------------------------------------------------------------------
// onehot_classify: combinational classifier of the source strobes.
//   i_en  : strobe vector (EN_W bits, may be wider than NUM_SRC)
//   o_cls : CLS_ZERO / CLS_ONE / CLS_MULTI
//   o_idx : lowest set index below NUM_SRC, IDLE_SEL when there is none
// Any set bit at or above NUM_SRC forces CLS_MULTI.
// -----------------------------------------------------------------------------
module onehot_classify
  import bus_pkg::*;
#(
  parameter int EN_W    = NUM_SRC,
  parameter int NUM_SRC = bus_pkg::NUM_SRC,
  parameter int SEL_W   = bus_pkg::SEL_W
) (
  input  logic [EN_W-1:0]  i_en,
  output onehot_cls_t      o_cls,
  output logic [SEL_W-1:0] o_idx
);

  logic w_found;
  logic w_multi;

  // Popcount limited to "more than one": a second hit or an unmapped bit
  // is enough to call MULTI, so no full adder tree is needed.
  always_comb begin
    w_found = 1'b0;
    w_multi = 1'b0;
    o_idx   = SEL_W'(IDLE_SEL);
    for (int i = 0; i < EN_W; i++) begin
      if (i_en[i]) begin
        if (w_found || (i >= NUM_SRC)) begin
          w_multi = 1'b1;
        end
        if (!w_found && (i < NUM_SRC)) begin
          w_found = 1'b1;
          o_idx   = SEL_W'(i);
        end
      end
    end
    if (w_multi) begin
      o_cls = CLS_MULTI;
    end else if (w_found) begin
      o_cls = CLS_ONE;
    end else begin
      o_cls = CLS_ZERO;
    end
  end

endmodule

// File: rtl/bus_select_encoder.sv
// -----------------------------------------------------------------------------
// bus_select_encoder: turns one-hot source strobes into a registered 5-bit
// bus mux select, with multi-driver/no-driver detection and stall hold.
//   clk : system clock (rising edge)
//   clr : asynchronous active-low reset
//   bus : bus_select_encoder_if.slave (out_en, hold, fault_ack in;
//         select, bus_valid, fault, fault_cnt out)
// Optional build macro BUS_ENC_PRIORITY_EN: multi-driver cycles do not enter
// FAULT; the lowest mapped index wins, and the event is still counted.
// -----------------------------------------------------------------------------
module bus_select_encoder
  import bus_pkg::*;
#(
  parameter int EN_W    = bus_pkg::NUM_SRC,
  parameter int NUM_SRC = bus_pkg::NUM_SRC,
  parameter int SEL_W   = bus_pkg::SEL_W,
  parameter int CNT_W   = bus_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               clr,
  bus_select_encoder_if.slave bus
);

  localparam logic [SEL_W-1:0] IDLE_CODE = SEL_W'(IDLE_SEL);

  bus_enc_state_t   r_state, w_state_nxt;
  logic [SEL_W-1:0] r_select, w_select_nxt;
  logic             r_bus_valid, w_valid_nxt;
  logic [CNT_W-1:0] r_fault_cnt;
  logic             w_cnt_inc;
  onehot_cls_t      w_cls;
  logic [SEL_W-1:0] w_idx;

  onehot_classify #(
    .EN_W    (EN_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_classify (
    .i_en  (bus.out_en),
    .o_cls (w_cls),
    .o_idx (w_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_select_nxt = r_select;
    w_valid_nxt  = r_bus_valid;
    w_cnt_inc    = 1'b0;
    case (r_state)
      FAULT: begin
        // hold is ignored here; only fault_ack leaves FAULT.
        w_select_nxt = IDLE_CODE;
        w_valid_nxt  = 1'b0;
        if (bus.fault_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        if (!bus.hold) begin
          case (w_cls)
            CLS_ONE: begin
              w_state_nxt  = DRIVE;
              w_select_nxt = w_idx;
              w_valid_nxt  = 1'b1;
            end
            CLS_MULTI: begin
              w_cnt_inc = 1'b1;
`ifdef BUS_ENC_PRIORITY_EN
              // Only unmapped bits set: nothing legal to drive, go idle.
              w_select_nxt = w_idx;
              w_valid_nxt  = (w_idx != IDLE_CODE);
              w_state_nxt  = (w_idx != IDLE_CODE) ? DRIVE : IDLE;
`else
              w_state_nxt  = FAULT;
              w_select_nxt = IDLE_CODE;
              w_valid_nxt  = 1'b0;
`endif
            end
            default: begin
              w_state_nxt  = IDLE;
              w_select_nxt = IDLE_CODE;
              w_valid_nxt  = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= IDLE;
      r_select    <= IDLE_CODE;
      r_bus_valid <= 1'b0;
      r_fault_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_select    <= w_select_nxt;
      r_bus_valid <= w_valid_nxt;
      // Saturate instead of wrapping so a storm of faults stays visible.
      if (w_cnt_inc && (r_fault_cnt != {CNT_W{1'b1}})) begin
        r_fault_cnt <= r_fault_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.select    = r_select;
  assign bus.bus_valid = r_bus_valid;
  assign bus.fault     = (r_state == FAULT);
  assign bus.fault_cnt = r_fault_cnt;

endmodule

// File: tb/tb_bus_select_encoder.sv
// -----------------------------------------------------------------------------
// tb_bus_select_encoder: directed self-checking bench for bus_select_encoder.
// Builds with or without BUS_ENC_PRIORITY_EN; expectations follow the build.
// -----------------------------------------------------------------------------
module tb_bus_select_encoder;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bus_select_encoder_if #(.EN_W(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_if ();

  bus_select_encoder #(
    .EN_W    (NUM_SRC),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (u_if)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs set after this return are sampled at the next rising edge;
  // outputs are read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int sel, input int vld,
                           input int flt, input int cnt);
    check({tag, ".select"},    int'(u_if.select),    sel);
    check({tag, ".bus_valid"}, int'(u_if.bus_valid), vld);
    check({tag, ".fault"},     int'(u_if.fault),     flt);
    check({tag, ".fault_cnt"}, int'(u_if.fault_cnt), cnt);
  endtask

  localparam logic [NUM_SRC-1:0] MULTI_3_16 = (24'd1 << 3) | (24'd1 << 16);

  initial begin
    clr            = 1'b0;
    u_if.out_en    = '0;
    u_if.hold      = 1'b0;
    u_if.fault_ack = 1'b0;
    #12;
    check_all("reset_low", 24, 0, 0, 0);
    step();
    clr = 1'b1;
    step();
    check_all("reset_rel", 24, 0, 0, 0);

    // Back-to-back sources, then release to idle.
    u_if.out_en = 24'd1 << SRC_PC;
    step();
    check_all("pc", 20, 1, 0, 0);
    u_if.out_en = 24'd1 << SRC_MDR;
    step();
    check_all("mdr", 21, 1, 0, 0);
    u_if.out_en = '0;
    step();
    check_all("idle", 24, 0, 0, 0);

    // Hold freezes the select while another source is requested.
    u_if.out_en = 24'd1 << SRC_R5;
    step();
    check("r5.select", int'(u_if.select), 5);
    u_if.hold   = 1'b1;
    u_if.out_en = 24'd1 << SRC_R7;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold.select", int'(u_if.select), 5);
      check("hold.bus_valid", int'(u_if.bus_valid), 1);
    end
    u_if.hold = 1'b0;
    step();
    check("unhold.select", int'(u_if.select), 7);

    // Multi-driver event.
    u_if.out_en = MULTI_3_16;
    step();
`ifdef BUS_ENC_PRIORITY_EN
    check_all("multi", 3, 1, 0, 1);
`else
    check_all("multi", 24, 0, 1, 1);
`endif
    for (int i = 0; i < 5; i++) begin
      step();
    end
`ifdef BUS_ENC_PRIORITY_EN
    check_all("multi_stay", 3, 1, 0, 6);
`else
    check_all("multi_stay", 24, 0, 1, 1);
`endif

    // fault_ack with hold and out_en still multi: fault_ack wins in FAULT.
    u_if.hold      = 1'b1;
    u_if.fault_ack = 1'b1;
    step();
`ifdef BUS_ENC_PRIORITY_EN
    check_all("ack", 3, 1, 0, 6);
`else
    check_all("ack", 24, 0, 0, 1);
`endif
    u_if.hold      = 1'b0;
    u_if.fault_ack = 1'b0;
    u_if.out_en    = '0;
    step();
    check_all("after_ack", 24, 0, 0, `ifdef BUS_ENC_PRIORITY_EN 6 `else 1 `endif);

    // 260 further events: the counter must saturate, not wrap.
    for (int i = 0; i < 260; i++) begin
      u_if.out_en = MULTI_3_16;
      step();
      u_if.out_en    = '0;
      u_if.fault_ack = 1'b1;
      step();
      u_if.fault_ack = 1'b0;
    end
    step();
    check_all("saturate", 24, 0, 0, 255);

    // Asynchronous reset mid-cycle while driving source 23.
    u_if.out_en = 24'd1 << SRC_C;
    step();
    check("c.select", int'(u_if.select), 23);
    #2;
    clr = 1'b0;
    #1;
    check_all("async_rst", 24, 0, 0, 0);
    u_if.out_en = '0;
    #10;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
